// File: rtl/fifo_arb_pkg.sv
// Shared types and the round-robin search used by the FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic {ARB, BURST} arb_state_t;

  // The search works on a padded index space large enough for the biggest supported requester count.
  localparam int RR_MAX = 16;
  localparam int ID_W   = $clog2(RR_MAX);
  localparam int CNT_W  = $clog2(RR_MAX + 1);

  // First set bit of valid scanning upward from last+1, wrapping at num_req.
  function automatic logic [ID_W-1:0] rr_next(
    input logic [RR_MAX-1:0] valid,
    input logic [ID_W-1:0]   last,
    input logic [CNT_W-1:0]  num_req
  );
    logic [ID_W-1:0]  win;
    logic             found;
    logic [CNT_W-1:0] idx;
    win   = '0;
    found = 1'b0;
    for (int i = 1; i <= RR_MAX; i++) begin
      idx = CNT_W'(last) + CNT_W'(i);
      if (idx >= num_req) idx = idx - num_req;
      if (!found && (CNT_W'(i) <= num_req) && valid[idx[ID_W-1:0]]) begin
        win   = idx[ID_W-1:0];
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_picker.sv
// Combinational round-robin priority search over NUM_REQ valid bits.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         valid,
  input  logic [$clog2(NUM_REQ)-1:0] rr_last,
  output logic [$clog2(NUM_REQ)-1:0] winner,
  output logic                       any
);

  localparam int SEL_W = $clog2(NUM_REQ);

  logic [RR_MAX-1:0] valid_pad;

  generate
    for (genvar gi = 0; gi < RR_MAX; gi++) begin : g_pad
      if (gi < NUM_REQ) begin : g_used
        assign valid_pad[gi] = valid[gi];
      end else begin : g_unused
        assign valid_pad[gi] = 1'b0;
      end
    end
  endgenerate

  assign winner = SEL_W'(rr_next(valid_pad, ID_W'(rr_last), CNT_W'(NUM_REQ)));
  assign any    = |valid;

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ burst requesters.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int MAX_BURST    = 8,
  parameter int IDLE_TIMEOUT = 4
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_data,
  input  logic [NUM_REQ-1:0]                 req_last,
  output logic [NUM_REQ-1:0]                 req_ready,
  output logic [DATA_WIDTH-1:0]              fifo_data_in,
  output logic                               fifo_write_en,
  input  logic                               fifo_full,
  output logic                               grant_valid,
  output logic [$clog2(NUM_REQ)-1:0]         grant_id,
  output logic [$clog2(MAX_BURST+1)-1:0]     beat_count
);

  localparam int GID_W  = $clog2(NUM_REQ);
  localparam int BC_W   = $clog2(MAX_BURST + 1);
  localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);

  arb_state_t        state_reg, state_next;
  logic [GID_W-1:0]  owner_reg, owner_next;
  logic [GID_W-1:0]  rr_last_reg, rr_last_next;
  logic [BC_W-1:0]   beat_reg, beat_next;
  logic [IDLE_W-1:0] idle_reg, idle_next;

  logic [GID_W-1:0]      winner;
  logic                  any_valid;
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
  logic                  in_burst;
  logic                  owner_valid;
  logic                  owner_last;
  logic [BC_W-1:0]       beat_inc;
  logic [IDLE_W-1:0]     idle_inc;

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .valid   (req_valid),
    .rr_last (rr_last_reg),
    .winner  (winner),
    .any     (any_valid)
  );

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign data_arr[gi]  = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign req_ready[gi] = in_burst && !fifo_full && (owner_reg == GID_W'(gi));
    end
  endgenerate

  assign in_burst    = (state_reg == BURST);
  assign owner_valid = req_valid[owner_reg];
  assign owner_last  = req_last[owner_reg];
  assign beat_inc    = beat_reg + BC_W'(1);
  assign idle_inc    = idle_reg + IDLE_W'(1);

  assign fifo_write_en = in_burst && owner_valid && !fifo_full;
  assign fifo_data_in  = in_burst ? data_arr[owner_reg] : '0;
  assign grant_valid   = in_burst;
  assign grant_id      = in_burst ? owner_reg : '0;
  assign beat_count    = beat_reg;

  always_comb begin
    state_next   = state_reg;
    owner_next   = owner_reg;
    rr_last_next = rr_last_reg;
    beat_next    = beat_reg;
    idle_next    = idle_reg;
    if (state_reg == ARB) begin
      if (any_valid) begin
        state_next = BURST;
        owner_next = winner;
        beat_next  = '0;
        idle_next  = '0;
      end
    end else begin
      if (fifo_write_en) begin
        beat_next = beat_inc;
        idle_next = '0;
        // last and a full burst on the same beat collapse into one release
        if (owner_last || (beat_inc == BC_W'(MAX_BURST))) begin
          state_next   = ARB;
          rr_last_next = owner_reg;
        end
      end else if (!owner_valid) begin
        // only a silent owner ages; a FIFO-full stall with valid high never revokes
        idle_next = idle_inc;
        if (idle_inc == IDLE_W'(IDLE_TIMEOUT)) begin
          state_next   = ARB;
          rr_last_next = owner_reg;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= ARB;
      owner_reg   <= '0;
      rr_last_reg <= GID_W'(NUM_REQ - 1);
      beat_reg    <= '0;
      idle_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      owner_reg   <= owner_next;
      rr_last_reg <= rr_last_next;
      beat_reg    <= beat_next;
      idle_reg    <= idle_next;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter: per-requester beat sources, expected writes queued in order.
module tb_fifo_write_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  logic           clock = 1'b0;
  logic           reset;
  logic [NR-1:0]  req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]  req_last;
  logic [NR-1:0]  req_ready;
  logic [DW-1:0]  fifo_data_in;
  logic           fifo_write_en;
  logic           fifo_full;
  logic           grant_valid;
  logic [1:0]     grant_id;
  logic [3:0]     beat_count;

  always #5 clock = ~clock;

  fifo_write_arbiter #(
    .NUM_REQ      (4),
    .DATA_WIDTH   (8),
    .MAX_BURST    (8),
    .IDLE_TIMEOUT (4)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .fifo_data_in  (fifo_data_in),
    .fifo_write_en (fifo_write_en),
    .fifo_full     (fifo_full),
    .grant_valid   (grant_valid),
    .grant_id      (grant_id),
    .beat_count    (beat_count)
  );

  int   checks;
  int   errors;
  int   wr_count;
  int   cyc;
  exp_t exp_q[$];
  logic [7:0] src_data [NR][16];
  logic       src_last [NR][16];
  int         src_len  [NR];
  int         src_ptr  [NR];
  logic       reset_drv;
  logic       full_drv;

  function automatic logic [7:0] dat(input int r, input int k);
    return 8'(r * 64 + k);
  endfunction

  task automatic clear_src();
    for (int i = 0; i < NR; i++) begin
      src_len[i] = 0;
      src_ptr[i] = 0;
    end
  endtask

  // mode 0: no last, 1: last on every beat, 2: last on the final beat of this chunk
  task automatic load(input int r, input int n, input int mode);
    for (int k = 0; k < n; k++) begin
      src_data[r][src_len[r]] = dat(r, src_len[r]);
      src_last[r][src_len[r]] = (mode == 1) || (mode == 2 && k == n - 1);
      src_len[r]++;
    end
  endtask

  task automatic push_exp(input int r, input int k0, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.id   = 2'(r);
      e.data = dat(r, k0 + k);
      exp_q.push_back(e);
    end
  endtask

  // Drive at negedge, sample 1ns later; what is sampled is what the next posedge commits.
  task automatic run_cycle();
    exp_t e;
    @(negedge clock);
    reset     = reset_drv;
    fifo_full = full_drv;
    for (int i = 0; i < NR; i++) begin
      if (src_ptr[i] < src_len[i]) begin
        req_valid[i]         = 1'b1;
        req_data[i*DW +: DW] = src_data[i][src_ptr[i]];
        req_last[i]          = src_last[i][src_ptr[i]];
      end else begin
        req_valid[i]         = 1'b0;
        req_data[i*DW +: DW] = '0;
        req_last[i]          = 1'b0;
      end
    end
    #1;
    cyc++;
    if (!reset && fifo_write_en === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got id=%0d data=%h, required no write", grant_id, fifo_data_in);
      end else begin
        e = exp_q.pop_front();
        if (fifo_data_in !== e.data || grant_id !== e.id) begin
          errors++;
          $display("FAIL write_data: got id=%0d data=%h, required id=%0d data=%h",
                   grant_id, fifo_data_in, e.id, e.data);
        end
      end
      wr_count++;
      $display("write cycle=%0d id=%0d data=%h beat_count=%0d", cyc, grant_id, fifo_data_in, beat_count);
    end
    if (!reset) begin
      for (int i = 0; i < NR; i++)
        if (req_valid[i] && req_ready[i] === 1'b1) src_ptr[i]++;
    end
  endtask

  task automatic drain();
    int n = 0;
    bit busy;
    do begin
      run_cycle();
      n++;
      busy = (grant_valid !== 1'b0);
      for (int i = 0; i < NR; i++)
        if (src_ptr[i] < src_len[i]) busy = 1'b1;
    end while (busy && n < 60);
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL drain_timeout: got busy after %0d cycles, required idle", n);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_writes: got %0d missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset_drv = 1'b1;
    repeat (3) run_cycle();
    checks++;
    if (grant_valid !== 1'b0 || grant_id !== 2'd0 || beat_count !== 4'd0 ||
        req_ready !== 4'd0 || fifo_write_en !== 1'b0 || fifo_data_in !== 8'd0) begin
      errors++;
      $display("FAIL reset_outputs: got gv=%b id=%0d bc=%0d rdy=%b we=%b d=%h, required all 0",
               grant_valid, grant_id, beat_count, req_ready, fifo_write_en, fifo_data_in);
    end
    reset_drv = 1'b0;
    run_cycle();
    checks++;
    if (grant_valid !== 1'b0 || fifo_write_en !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got gv=%b we=%b, required 0 0", grant_valid, fifo_write_en);
    end
  endtask

  task automatic test_round_robin();
    int n = 0;
    clear_src();
    load(0, 2, 1);
    for (int r = 1; r < NR; r++) load(r, 1, 1);
    push_exp(0, 0, 1);
    push_exp(1, 0, 1);
    push_exp(2, 0, 1);
    push_exp(3, 0, 1);
    push_exp(0, 1, 1);
    do begin
      run_cycle();
      n++;
    end while (exp_q.size() != 0 && n < 40);
    checks++;
    if (n != 10) begin
      errors++;
      $display("FAIL rr_latency: got %0d cycles for 5 grants, required 10", n);
    end
    drain();
  endtask

  task automatic test_max_burst();
    int n = 0;
    int low = 0;
    int base;
    clear_src();
    load(2, 12, 0);
    push_exp(2, 0, 12);
    base = wr_count;
    do begin
      run_cycle();
      n++;
      if (grant_valid === 1'b0 && wr_count > base && wr_count - base < 12) begin
        low++;
        checks++;
        if (wr_count - base != 8 || beat_count !== 4'd8) begin
          errors++;
          $display("FAIL max_burst_gap: got writes=%0d bc=%0d, required writes=8 bc=8",
                   wr_count - base, beat_count);
        end
      end
    end while (wr_count - base < 12 && n < 60);
    checks++;
    if (low != 1 || wr_count - base != 12) begin
      errors++;
      $display("FAIL max_burst_release: got gap=%0d writes=%0d, required gap=1 writes=12", low, wr_count - base);
    end
    run_cycle();
    checks++;
    if (grant_valid !== 1'b1 || grant_id !== 2'd2 || beat_count !== 4'd4) begin
      errors++;
      $display("FAIL max_burst_tail: got gv=%b id=%0d bc=%0d, required gv=1 id=2 bc=4",
               grant_valid, grant_id, beat_count);
    end
    drain();
  endtask

  task automatic test_full_stall();
    int n = 0;
    int base;
    clear_src();
    load(1, 6, 2);
    push_exp(1, 0, 6);
    base = wr_count;
    do begin
      run_cycle();
      n++;
    end while (wr_count - base < 2 && n < 20);
    full_drv = 1'b1;
    for (int c = 0; c < 10; c++) begin
      run_cycle();
      checks++;
      if (fifo_write_en !== 1'b0 || req_ready !== 4'd0 || grant_id !== 2'd1 || grant_valid !== 1'b1) begin
        errors++;
        $display("FAIL full_stall[%0d]: got we=%b rdy=%b id=%0d gv=%b, required we=0 rdy=0 id=1 gv=1",
                 c, fifo_write_en, req_ready, grant_id, grant_valid);
      end
    end
    full_drv = 1'b0;
    run_cycle();
    checks++;
    if (fifo_write_en !== 1'b1 || req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL full_resume: got we=%b rdy=%b, required we=1 rdy=0010", fifo_write_en, req_ready);
    end
    drain();
  endtask

  task automatic test_idle_timeout();
    int n = 0;
    int idle = 0;
    int base;
    clear_src();
    load(0, 2, 0);
    push_exp(0, 0, 2);
    push_exp(3, 0, 1);
    base = wr_count;
    do begin
      run_cycle();
      n++;
    end while (wr_count - base < 2 && n < 20);
    load(3, 1, 1);
    n = 0;
    do begin
      run_cycle();
      n++;
      if (grant_valid === 1'b1 && grant_id === 2'd0) idle++;
    end while (grant_valid === 1'b1 && n < 20);
    checks++;
    if (idle != 4) begin
      errors++;
      $display("FAIL idle_timeout: got %0d idle cycles before revoke, required 4", idle);
    end
    run_cycle();
    checks++;
    if (grant_valid !== 1'b1 || grant_id !== 2'd3) begin
      errors++;
      $display("FAIL idle_next_grant: got gv=%b id=%0d, required gv=1 id=3", grant_valid, grant_id);
    end
    drain();
  endtask

  task automatic test_reset_mid_burst();
    int n = 0;
    int base;
    clear_src();
    load(1, 1, 1);
    load(2, 6, 0);
    push_exp(1, 0, 1);
    push_exp(2, 0, 3);
    base = wr_count;
    do begin
      run_cycle();
      n++;
    end while (wr_count - base < 4 && n < 30);
    load(0, 1, 1);
    reset_drv = 1'b1;
    run_cycle();
    reset_drv = 1'b0;
    push_exp(0, 0, 1);
    push_exp(2, 3, 3);
    run_cycle();
    checks++;
    if (grant_valid !== 1'b0 || grant_id !== 2'd0 || beat_count !== 4'd0 ||
        req_ready !== 4'd0 || fifo_write_en !== 1'b0 || fifo_data_in !== 8'd0) begin
      errors++;
      $display("FAIL reset_mid_burst: got gv=%b id=%0d bc=%0d rdy=%b we=%b d=%h, required all 0",
               grant_valid, grant_id, beat_count, req_ready, fifo_write_en, fifo_data_in);
    end
    run_cycle();
    checks++;
    if (grant_valid !== 1'b1 || grant_id !== 2'd0) begin
      errors++;
      $display("FAIL post_reset_grant: got gv=%b id=%0d, required gv=1 id=0", grant_valid, grant_id);
    end
    drain();
  endtask

  task automatic test_last_at_max();
    int n = 0;
    int low = 0;
    int base;
    clear_src();
    load(1, 8, 2);
    load(1, 1, 1);
    push_exp(1, 0, 9);
    base = wr_count;
    do begin
      run_cycle();
      n++;
      if (grant_valid === 1'b0 && wr_count > base) begin
        low++;
        checks++;
        if (beat_count !== 4'd8 || wr_count - base != 8) begin
          errors++;
          $display("FAIL last_max_gap: got bc=%0d writes=%0d, required bc=8 writes=8",
                   beat_count, wr_count - base);
        end
      end
    end while (wr_count - base < 9 && n < 40);
    checks++;
    if (n != 11 || low != 1) begin
      errors++;
      $display("FAIL last_max_release: got cycles=%0d gaps=%0d, required cycles=11 gaps=1", n, low);
    end
    drain();
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    wr_count  = 0;
    cyc       = 0;
    reset     = 1'b1;
    reset_drv = 1'b1;
    full_drv  = 1'b0;
    fifo_full = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    clear_src();
    test_reset();
    test_round_robin();
    test_max_burst();
    test_full_stall();
    test_idle_timeout();
    test_reset_mid_burst();
    test_last_at_max();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
